// File: rtl/riscv_configs.sv
// rtl/riscv_configs.sv - shared RISC-V opcodes, sequencer state encodings and datapath mux selects
package riscv_configs;

  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_JAL     = 7'h6F;
  localparam logic [6:0] OP_JALR    = 7'h67;
  localparam logic [6:0] OP_ALU     = 7'h33;
  localparam logic [6:0] OP_ALU_IMM = 7'h13;
  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_AUIPC   = 7'h17;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SRC_IMM   = 2'd1;
  localparam logic [1:0] PC_SRC_ALU   = 2'd2;

  localparam logic [1:0] ALU_A_RS1    = 2'd0;
  localparam logic [1:0] ALU_A_OLD_PC = 2'd1;
  localparam logic [1:0] ALU_A_ZERO   = 2'd2;

  localparam logic [1:0] ALU_B_RS2    = 2'd0;
  localparam logic [1:0] ALU_B_IMM    = 2'd1;

  localparam logic [1:0] RES_ALU      = 2'd0;
  localparam logic [1:0] RES_MEM      = 2'd1;
  localparam logic [1:0] RES_PC4      = 2'd2;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_ALU,
    CLS_ALU_IMM,
    CLS_LUI,
    CLS_AUIPC
  } op_class_e;

  function automatic op_class_e decode_op(input logic [6:0] op);
    op_class_e cls;
    case (op)
      OP_LOAD:    cls = CLS_LOAD;
      OP_STORE:   cls = CLS_STORE;
      OP_BRANCH:  cls = CLS_BRANCH;
      OP_JAL:     cls = CLS_JAL;
      OP_JALR:    cls = CLS_JALR;
      OP_ALU:     cls = CLS_ALU;
      OP_ALU_IMM: cls = CLS_ALU_IMM;
      OP_LUI:     cls = CLS_LUI;
      OP_AUIPC:   cls = CLS_AUIPC;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/riscv_perf_cnt.sv
// rtl/riscv_perf_cnt.sv - free-running cycle and retired-instruction counters, wrapping at 2^32
module riscv_perf_cnt (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_retire,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_instret_cnt
);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_cycle_cnt   <= 32'd0;
      o_instret_cnt <= 32'd0;
    end else begin
      o_cycle_cnt <= o_cycle_cnt + 32'd1;
      if (i_retire) begin
        o_instret_cnt <= o_instret_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/riscv_mc_sequencer.sv
// rtl/riscv_mc_sequencer.sv - multi-cycle RV32I control FSM; RISCV_MC_PERF_CNT_EN adds cycle/instret counters
module riscv_mc_sequencer
  import riscv_configs::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [6:0]  i_op,
  input  logic [2:0]  i_funct3,
  input  logic        i_take_branch,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_ir_wr,
  output logic        o_pc_wr,
  output logic        o_reg_wr,
  output logic [1:0]  o_pc_src,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_result_src,
  output logic        o_illegal,
  output logic [2:0]  o_state
`ifdef RISCV_MC_PERF_CNT_EN
  ,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_instret_cnt
`endif
);

  state_e    state;
  state_e    next_state;
  op_class_e cls;

  logic       imem_req_c;
  logic       dmem_req_c;
  logic       dmem_we_c;
  logic       ir_wr_c;
  logic       pc_wr_c;
  logic       reg_wr_c;
  logic       illegal_c;
  logic [1:0] pc_src_c;
  logic [1:0] alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] result_src_c;

  // The step sequence depends only on the opcode; funct3 is consumed by the ALU decoder.
  logic unused_funct3;
  assign unused_funct3 = ^i_funct3;

  assign cls = decode_op(i_op);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    ir_wr_c      = 1'b0;
    pc_wr_c      = 1'b0;
    reg_wr_c     = 1'b0;
    illegal_c    = 1'b0;
    pc_src_c     = PC_SRC_PLUS4;
    alu_src_a_c  = ALU_A_RS1;
    alu_src_b_c  = ALU_B_RS2;
    result_src_c = RES_ALU;

    case (state)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (i_imem_ack) begin
          ir_wr_c    = 1'b1;
          pc_wr_c    = 1'b1;
          next_state = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
          illegal_c  = 1'b1;
          next_state = ST_FETCH;
        end else begin
          next_state = ST_EXEC;
        end
      end

      ST_EXEC: begin
        next_state = ST_WB;
        case (cls)
          CLS_LOAD, CLS_STORE: begin
            alu_src_b_c = ALU_B_IMM;
            next_state  = ST_MEM;
          end
          CLS_BRANCH: begin
            pc_wr_c    = i_take_branch;
            pc_src_c   = PC_SRC_IMM;
            next_state = ST_FETCH;
          end
          CLS_JAL: begin
            pc_wr_c  = 1'b1;
            pc_src_c = PC_SRC_IMM;
          end
          CLS_JALR: begin
            alu_src_b_c = ALU_B_IMM;
            pc_wr_c     = 1'b1;
            pc_src_c    = PC_SRC_ALU;
          end
          CLS_ALU_IMM: begin
            alu_src_b_c = ALU_B_IMM;
          end
          CLS_LUI: begin
            alu_src_a_c = ALU_A_ZERO;
            alu_src_b_c = ALU_B_IMM;
          end
          CLS_AUIPC: begin
            alu_src_a_c = ALU_A_OLD_PC;
            alu_src_b_c = ALU_B_IMM;
          end
          CLS_ALU: begin
            next_state = ST_WB;
          end
          default: begin
            next_state = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls == CLS_STORE);
        if (i_dmem_ack) begin
          next_state = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end
      end

      ST_WB: begin
        reg_wr_c   = 1'b1;
        next_state = ST_FETCH;
        case (cls)
          CLS_LOAD:          result_src_c = RES_MEM;
          CLS_JAL, CLS_JALR: result_src_c = RES_PC4;
          default:           result_src_c = RES_ALU;
        endcase
      end

      default: begin
        next_state = ST_FETCH;
      end
    endcase
  end

  // Outputs are masked by reset so a pending request drops the moment reset asserts.
  assign o_imem_req   = i_rstn & imem_req_c;
  assign o_dmem_req   = i_rstn & dmem_req_c;
  assign o_dmem_we    = i_rstn & dmem_we_c;
  assign o_ir_wr      = i_rstn & ir_wr_c;
  assign o_pc_wr      = i_rstn & pc_wr_c;
  assign o_reg_wr     = i_rstn & reg_wr_c;
  assign o_illegal    = i_rstn & illegal_c;
  assign o_pc_src     = {2{i_rstn}} & pc_src_c;
  assign o_alu_src_a  = {2{i_rstn}} & alu_src_a_c;
  assign o_alu_src_b  = {2{i_rstn}} & alu_src_b_c;
  assign o_result_src = {2{i_rstn}} & result_src_c;
  assign o_state      = state;

`ifdef RISCV_MC_PERF_CNT_EN
  logic retire;

  // Retirement is any return to FETCH except the illegal-opcode abort out of DECODE.
  assign retire = (state != ST_FETCH) && (state != ST_DECODE) && (next_state == ST_FETCH);

  riscv_perf_cnt u_perf_cnt (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_retire      (retire),
    .o_cycle_cnt   (o_cycle_cnt),
    .o_instret_cnt (o_instret_cnt)
  );
`endif

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// tb/tb_riscv_mc_sequencer.sv - scoreboard bench for riscv_mc_sequencer with a per-instruction trace model
module tb_riscv_mc_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        take;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, illegal;
  logic [1:0]  pc_src, alu_a, alu_b, result_src;
  logic [2:0]  state;
`ifdef RISCV_MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  riscv_mc_sequencer dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_op          (op),
    .i_funct3      (funct3),
    .i_take_branch (take),
    .i_imem_ack    (imem_ack),
    .i_dmem_ack    (dmem_ack),
    .o_imem_req    (imem_req),
    .o_dmem_req    (dmem_req),
    .o_dmem_we     (dmem_we),
    .o_ir_wr       (ir_wr),
    .o_pc_wr       (pc_wr),
    .o_reg_wr      (reg_wr),
    .o_pc_src      (pc_src),
    .o_alu_src_a   (alu_a),
    .o_alu_src_b   (alu_b),
    .o_result_src  (result_src),
    .o_illegal     (illegal),
    .o_state       (state)
`ifdef RISCV_MC_PERF_CNT_EN
    ,
    .o_cycle_cnt   (cycle_cnt),
    .o_instret_cnt (instret_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_wr;
    logic       pc_wr;
    logic       reg_wr;
    logic [1:0] pc_src;
    logic [1:0] result_src;
    logic       illegal;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc_q[$];
  int unsigned ret_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;

  function automatic exp_t observed();
    exp_t a;
    a = {state, imem_req, dmem_req, dmem_we, ir_wr, pc_wr, reg_wr, pc_src, result_src, illegal};
    return a;
  endfunction

  // Monitor: one expected step is consumed at every falling edge while one is queued.
  initial begin
    exp_t e, a;
    int unsigned c, r;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        r = ret_q.pop_front();
        a = observed();
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL trace t=%0t: got st=%0d bits=%b expected st=%0d bits=%b", $time, a.st, a, e.st, e);
        end
`ifdef RISCV_MC_PERF_CNT_EN
        n_vec++;
        if (cycle_cnt !== c || instret_cnt !== r) begin
          n_err++;
          $display("FAIL perf t=%0t: got cycle=%0d instret=%0d expected cycle=%0d instret=%0d",
                   $time, cycle_cnt, instret_cnt, c, r);
        end
`else
        if (c == 32'hFFFF_FFFF && r == 32'hFFFF_FFFF) $display("note: counter wrap");
`endif
      end
    end
  end

  task automatic drive_cycle(input logic [6:0] op_v, input logic ia, input logic da,
                             input logic tk, input exp_t e);
    @(posedge clk);
    exp_cyc++;
    #1;
    op       = op_v;
    funct3   = 3'($urandom);
    imem_ack = ia;
    dmem_ack = da;
    take     = tk;
    exp_q.push_back(e);
    cyc_q.push_back(exp_cyc);
    ret_q.push_back(exp_ret);
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17};
  endfunction

  // Reference: expected per-cycle trace of one instruction given its opcode, ack delays and branch outcome.
  task automatic run_instr(input logic [6:0] op_v, input int fdly, input int mdly, input logic tk);
    exp_t e;
    bit   is_load, is_store, is_branch, is_jump;
    is_load   = (op_v == 7'h03);
    is_store  = (op_v == 7'h23);
    is_branch = (op_v == 7'h63);
    is_jump   = (op_v == 7'h6F) || (op_v == 7'h67);

    e = '0;
    e.imem_req = 1'b1;
    for (int i = 0; i < fdly; i++) drive_cycle(7'($urandom), 1'b0, 1'b0, 1'($urandom), e);
    e.ir_wr = 1'b1;
    e.pc_wr = 1'b1;
    drive_cycle(7'($urandom), 1'b1, 1'b0, 1'($urandom), e);

    e = '0;
    e.st = 3'd1;
    if (!is_legal(op_v)) begin
      e.illegal = 1'b1;
      drive_cycle(op_v, 1'b0, 1'b0, 1'($urandom), e);
      return;
    end
    drive_cycle(op_v, 1'b0, 1'b0, 1'($urandom), e);

    e = '0;
    e.st = 3'd2;
    if (is_branch) begin
      e.pc_wr  = tk;
      e.pc_src = 2'd1;
    end else if (op_v == 7'h6F) begin
      e.pc_wr  = 1'b1;
      e.pc_src = 2'd1;
    end else if (op_v == 7'h67) begin
      e.pc_wr  = 1'b1;
      e.pc_src = 2'd2;
    end
    drive_cycle(op_v, 1'b0, 1'b0, tk, e);
    if (is_branch) begin
      exp_ret++;
      return;
    end

    if (is_load || is_store) begin
      e = '0;
      e.st       = 3'd3;
      e.dmem_req = 1'b1;
      e.dmem_we  = is_store;
      for (int i = 0; i < mdly; i++) drive_cycle(op_v, 1'b0, 1'b0, 1'($urandom), e);
      drive_cycle(op_v, 1'b0, 1'b1, 1'($urandom), e);
      if (is_store) begin
        exp_ret++;
        return;
      end
    end

    e = '0;
    e.st         = 3'd4;
    e.reg_wr     = 1'b1;
    e.result_src = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
    drive_cycle(op_v, 1'b0, 1'b0, 1'($urandom), e);
    exp_ret++;
  endtask

  task automatic check_idle(input string name, input logic want_imem);
    exp_t a, e;
    a = observed();
    e = '0;
    e.imem_req = want_imem;
    n_vec++;
    if (a !== e || alu_a !== 2'd0 || alu_b !== 2'd0) begin
      n_err++;
      $display("FAIL %s: got bits=%b alu=%0d/%0d expected bits=%b alu=0/0", name, a, alu_a, alu_b, e);
    end
`ifdef RISCV_MC_PERF_CNT_EN
    n_vec++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL %s counters: got %0d/%0d expected 0/0", name, cycle_cnt, instret_cnt);
    end
`endif
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn    = 1'b1;
    exp_cyc = 0;
    exp_ret = 0;
    #1;
    check_idle("post_reset_fetch", 1'b1);
  endtask

  // Reach MEM of a load, leave dmem waiting, then reset mid-request.
  task automatic abort_in_mem();
    exp_t e;
    e = '0;
    e.imem_req = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
    drive_cycle(7'h00, 1'b1, 1'b0, 1'b0, e);
    e = '0; e.st = 3'd1;
    drive_cycle(7'h03, 1'b0, 1'b0, 1'b0, e);
    e = '0; e.st = 3'd2;
    drive_cycle(7'h03, 1'b0, 1'b0, 1'b0, e);
    e = '0; e.st = 3'd3; e.dmem_req = 1'b1;
    drive_cycle(7'h03, 1'b0, 1'b0, 1'b0, e);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_idle("reset_drops_dmem", 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_idle("held_in_reset", 1'b0);
    release_reset();
  endtask

  localparam int NRAND = 150;

  initial begin
    logic [6:0] legal_ops [9];
    logic [6:0] rop;
    legal_ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h37, 7'h17};
    rstn = 1'b0; op = '0; funct3 = '0; take = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #12;
    check_idle("in_reset", 1'b0);
    release_reset();

    run_instr(7'h33, 0, 0, 1'b0);
    run_instr(7'h03, 0, 3, 1'b0);
    run_instr(7'h63, 0, 0, 1'b1);
    run_instr(7'h63, 0, 0, 1'b0);
    run_instr(7'h7F, 0, 0, 1'b0);
    run_instr(7'h23, 0, 0, 1'b0);
    run_instr(7'h6F, 2, 0, 1'b0);
    run_instr(7'h67, 1, 0, 1'b1);
    run_instr(7'h37, 0, 0, 1'b0);
    run_instr(7'h17, 3, 0, 1'b0);
    run_instr(7'h23, 1, 2, 1'b0);

    abort_in_mem();

    for (int n = 0; n < NRAND; n++) begin
      if ($urandom_range(0, 7) == 0) rop = 7'($urandom);
      else rop = legal_ops[$urandom_range(0, 8)];
      run_instr(rop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending steps expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
